dcache_lsu_ctrl: RTL and testbench
==================================

Name: dcache_lsu_ctrl

Overview:
- MEM-stage load/store unit that sits directly upstream of the DCache stall/flush control logic.
- Decodes the LA32 load/store instruction in MEM, issues one request on a req/addr_ok/data_ok memory port, and aligns load data.
- Drives `DCache_ready`, which the stall/flush control consumes: low while an access is outstanding, high otherwise.
- Blocking, one access at a time; detects misaligned addresses and reports them without touching memory.

Parameters:
- CNT_W, 32, width of performance counters (used only when LSU_PERF_CNT_EN is defined).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- inst  in  32  instruction currently in MEM
- inst_valid  in  1  MEM holds a valid instruction
- addr  in  32  effective address from EX
- st_data  in  32  rk/rd store source value
- stage_advance  in  1  MEM hands its instruction to WB at the end of this cycle
- flush  in  1  kill MEM instruction (exception/branch)
- DCache_ready  out  1  0 = access outstanding, stall pipeline
- load_data  out  32  aligned, extended load result; valid while `DCache_ready` = 1 after a load
- ale  out  1  address-misaligned exception for the current MEM instruction
- mem_req  out  1  request valid
- mem_wr  out  1  1 = store
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_wstrb  out  4  byte enables (0 for loads)
- mem_wdata  out  32  lane-replicated store data
- mem_addr_ok  in  1  request accepted this cycle
- mem_data_ok  in  1  load data / store completion this cycle
- mem_rdata  in  32  load word

Behaviour:
- Decode on inst[31:22]:
  - ld.b 0x0A0, ld.h 0x0A1, ld.w 0x0A2
  - st.b 0x0A4, st.h 0x0A5, st.w 0x0A6
  - ld.bu 0x0A8, ld.hu 0x0A9
  - anything else is non-memory.
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0. This gives ale=1 combinationally, no request, and `DCache_ready`=1.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - `DCache_ready` = ~(inst_valid & is_mem & ~misaligned & ~flush).
  - On such an access, latch op, addr[1:0] and the mem_* fields, then go to REQ next cycle.
- REQ:
  - mem_req=1 with mem_* fields held stable until mem_addr_ok; the request is never withdrawn.
  - On mem_addr_ok, go to WAIT.
- WAIT:
  - On mem_data_ok, register load_data; if cancelled, go to IDLE, otherwise go to DONE.
  - mem_data_ok arriving in the same cycle as addr_ok is legal; in that case go directly to DONE, or to IDLE if cancelled.
- DONE:
  - `DCache_ready`=1 and load_data is held.
  - On stage_advance or flush, go to IDLE.
- Flush in REQ or WAIT sets a cancel flag; the handshake still completes, the data is discarded, and the FSM returns to IDLE. `DCache_ready` stays 0 until then.
- Store wstrb and wdata by op:
  - st.b: 4'b0001<<addr[1:0], {4{st_data[7:0]}}
  - st.h: 4'b0011<<addr[1:0], {2{st_data[15:0]}}
  - st.w: 4'hF, st_data
- Load extraction:
  - Byte lane is addr[1:0] and half lane is addr[1].
  - ld.b / ld.h sign-extend; ld.bu / ld.hu zero-extend; ld.w passes the word through.
- Store load_data = 0.
- Reset (any state, including mid-transaction):
  - FSM goes to IDLE; mem_req, mem_wr, mem_wstrb, load_data and the cancel flag clear.
  - mem_addr and mem_wdata are 0.
  - The memory side is reset in the same cycle.
- `DCache_ready` after reset is 1 unless IDLE sees a valid access.

Optional Feature:
- LSU_PERF_CNT_EN defined: adds CNT_W-bit output ports load_cnt, store_cnt and stall_cnt.
  - load_cnt / store_cnt increment on each non-cancelled mem_data_ok.
  - stall_cnt increments every cycle `DCache_ready`=0.
  - All counters reset to 0 and wrap at 2^CNT_W.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- ld.w addr 0x1000, addr_ok 2 cycles after req, data_ok 3 cycles later with 0xDEADBEEF -> `DCache_ready` low from the first cycle until DONE, load_data = 0xDEADBEEF, mem_wstrb = 0.
- ld.b addr 0x1003, rdata 0x80112233 -> load_data 0xFFFFFF80; ld.bu at the same address -> 0x00000080; ld.hu addr 0x1002 -> 0x00008011.
- st.h addr 0x2002, st_data 0x1234ABCD -> mem_wr=1, mem_addr 0x2000, wstrb 4'b1100, wdata 0xABCDABCD.
- ld.w addr 0x1002 -> ale=1, mem_req never asserts, `DCache_ready`=1.
- flush in WAIT for ld.w -> FSM holds `DCache_ready` low until data_ok, then returns to IDLE; no DONE; with LSU_PERF_CNT_EN, load_cnt unchanged.
- rst asserted in REQ -> next cycle mem_req=0, FSM in IDLE, all counters 0; a subsequent st.w issues normally.

Source files
------------

// File: rtl/dcache_lsu_ctrl.sv
// rtl/dcache_lsu_ctrl.sv - MEM-stage LA32 load/store unit driving a req/addr_ok/data_ok port and DCache_ready
// Define LSU_PERF_CNT_EN to add the load_cnt/store_cnt/stall_cnt performance counters.
module dcache_lsu_ctrl
`ifdef LSU_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  input  logic        stage_advance,
  input  logic        flush,
  output logic        DCache_ready,
  output logic [31:0] load_data,
  output logic        ale,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q;
  logic        cancel_q, req_q, wr_q, sext_q;
  logic [29:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q, load_data_q;
  logic [1:0]  off_q, size_q;

  logic        dec_load, dec_store, dec_sext, is_mem, misaligned, start, complete;
  logic [1:0]  dec_size;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d, load_ext_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unused_inst;

  assign unused_inst = ^inst[21:0];

  // dec_size: 0 = byte, 1 = half, 2 = word
  always_comb begin
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_size  = 2'd0;
    dec_sext  = 1'b0;
    case (inst[31:22])
      10'h0A0: begin dec_load = 1'b1; dec_sext = 1'b1; end
      10'h0A1: begin dec_load = 1'b1; dec_sext = 1'b1; dec_size = 2'd1; end
      10'h0A2: begin dec_load = 1'b1; dec_size = 2'd2; end
      10'h0A4: dec_store = 1'b1;
      10'h0A5: begin dec_store = 1'b1; dec_size = 2'd1; end
      10'h0A6: begin dec_store = 1'b1; dec_size = 2'd2; end
      10'h0A8: dec_load = 1'b1;
      10'h0A9: begin dec_load = 1'b1; dec_size = 2'd1; end
      default: ;
    endcase
  end

  assign is_mem     = dec_load | dec_store;
  assign misaligned = ((dec_size == 2'd1) && addr[0]) || ((dec_size == 2'd2) && (addr[1:0] != 2'b00));
  assign ale        = inst_valid & is_mem & misaligned;
  assign start      = inst_valid & is_mem & ~misaligned & ~flush;

  always_comb begin
    wstrb_d = 4'h0;
    wdata_d = 32'h0;
    if (dec_store) begin
      case (dec_size)
        2'd0:    begin wstrb_d = 4'b0001 << addr[1:0]; wdata_d = {4{st_data[7:0]}}; end
        2'd1:    begin wstrb_d = 4'b0011 << addr[1:0]; wdata_d = {2{st_data[15:0]}}; end
        default: begin wstrb_d = 4'hF; wdata_d = st_data; end
      endcase
    end
  end

  assign byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
  assign half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (size_q)
      2'd0:    load_ext_d = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'd1:    load_ext_d = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_ext_d = mem_rdata;
    endcase
  end

  // data_ok may coincide with addr_ok, so completion is also possible straight from REQ
  assign complete = mem_data_ok && (((state_q == REQ) && mem_addr_ok) || (state_q == WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cancel_q    <= 1'b0;
      req_q       <= 1'b0;
      wr_q        <= 1'b0;
      sext_q      <= 1'b0;
      addr_q      <= 30'h0;
      wstrb_q     <= 4'h0;
      wdata_q     <= 32'h0;
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      load_data_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          req_q   <= 1'b1;
          wr_q    <= dec_store;
          addr_q  <= addr[31:2];
          wstrb_q <= wstrb_d;
          wdata_q <= wdata_d;
          off_q   <= addr[1:0];
          size_q  <= dec_size;
          sext_q  <= dec_sext;
          state_q <= REQ;
        end
        REQ: begin
          if (flush) cancel_q <= 1'b1;
          if (mem_addr_ok) begin
            req_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: if (flush) cancel_q <= 1'b1;
        DONE: if (stage_advance || flush) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (complete) begin
        load_data_q <= wr_q ? 32'h0 : load_ext_d;
        cancel_q    <= 1'b0;
        state_q     <= (cancel_q || flush) ? IDLE : DONE;
      end
    end
  end

  assign DCache_ready = (state_q == IDLE) ? ~start : (state_q == DONE);
  assign load_data    = load_data_q;
  assign mem_req      = req_q;
  assign mem_wr       = wr_q;
  assign mem_addr     = {addr_q, 2'b00};
  assign mem_wstrb    = wstrb_q;
  assign mem_wdata    = wdata_q;

`ifdef LSU_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  logic [CNT_W-1:0] load_cnt_q, store_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (complete && !(cancel_q || flush)) begin
        if (wr_q) store_cnt_q <= store_cnt_q + CNT_ONE;
        else      load_cnt_q  <= load_cnt_q + CNT_ONE;
      end
      if (!DCache_ready) stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_lsu_ctrl.sv
// tb/tb_dcache_lsu_ctrl.sv - self-checking bench for dcache_lsu_ctrl with a behavioural memory/LSU model
`timescale 1ns/1ps
module tb_dcache_lsu_ctrl;
  localparam logic [9:0] OP_LDB = 10'h0A0, OP_LDH = 10'h0A1, OP_LDW = 10'h0A2;
  localparam logic [9:0] OP_STB = 10'h0A4, OP_STH = 10'h0A5, OP_STW = 10'h0A6;
  localparam logic [9:0] OP_LDBU = 10'h0A8, OP_LDHU = 10'h0A9;

  logic clk = 1'b0;
  logic rst, inst_valid, stage_advance, flush, mem_addr_ok, mem_data_ok;
  logic [31:0] inst, addr, st_data, mem_rdata;
  logic DCache_ready, ale, mem_req, mem_wr;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] load_cnt, store_cnt, stall_cnt;
`endif

  dcache_lsu_ctrl dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .addr(addr), .st_data(st_data),
    .stage_advance(stage_advance), .flush(flush), .DCache_ready(DCache_ready), .load_data(load_data),
    .ale(ale), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
`ifdef LSU_PERF_CNT_EN
    , .load_cnt(load_cnt), .store_cnt(store_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        obs_ready0, obs_ale, obs_req_seen, obs_unstable, obs_timeout, obs_wr;
  logic [31:0] obs_addr, obs_wdata, obs_ld;
  logic [3:0]  obs_wstrb;
  int          obs_low;

  function automatic logic [31:0] ref_load(input logic [9:0] opc, input logic [1:0] off, input logic [31:0] w);
    logic [7:0] bytes [4];
    logic [7:0] b;
    logic [15:0] h;
    for (int k = 0; k < 4; k++) bytes[k] = w[8*k +: 8];
    b = bytes[off];
    h = {bytes[{off[1], 1'b1}], bytes[{off[1], 1'b0}]};
    case (opc)
      OP_LDB:  return {{24{b[7]}}, b};
      OP_LDBU: return {24'h0, b};
      OP_LDH:  return {{16{h[15]}}, h};
      OP_LDHU: return {16'h0, h};
      OP_LDW:  return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [9:0] opc, input logic [1:0] off);
    case (opc)
      OP_STB:  return 4'(1 << off);
      OP_STH:  return 4'(3 << off);
      OP_STW:  return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [9:0] opc, input logic [31:0] sd);
    case (opc)
      OP_STB:  return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
      OP_STH:  return {sd[15:0], sd[15:0]};
      OP_STW:  return sd;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_store_op(input logic [9:0] opc);
    return (opc == OP_STB) || (opc == OP_STH) || (opc == OP_STW);
  endfunction

  task automatic do_reset();
    rst = 1'b1; inst_valid = 1'b0; flush = 1'b0; stage_advance = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic retire();
    stage_advance = 1'b1;
    @(posedge clk);
    #1 stage_advance = 1'b0;
    inst_valid = 1'b0;
  endtask

  // Plays the memory side: addr_ok ack_dly cycles after req first seen, data_ok data_dly cycles after addr_ok
  task automatic run_access(input logic [9:0] opc, input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd, input int ack_dly, input int data_dly, input int flush_at);
    int cyc, since_req, since_ack;
    bit acked, data_sent, done;
    obs_req_seen = 1'b0; obs_unstable = 1'b0; obs_timeout = 1'b0; obs_low = 0; obs_ld = 32'h0;
    obs_wr = 1'b0; obs_addr = 32'h0; obs_wdata = 32'h0; obs_wstrb = 4'h0;
    inst = {opc, 22'($urandom)}; inst_valid = 1'b1; addr = a; st_data = sd; mem_rdata = rd;
    flush = 1'b0; stage_advance = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    #1;
    obs_ready0 = DCache_ready; obs_ale = ale;
    cyc = 0; since_req = 0; since_ack = 0; acked = 0; data_sent = 0; done = 0;
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      flush = (cyc == flush_at);
      if (flush_at > 0 && cyc > flush_at) inst_valid = 1'b0;
      #1;
      if (data_sent && DCache_ready) begin
        done = 1; obs_ld = load_data;
      end else if (cyc > 60) begin
        done = 1; obs_timeout = 1'b1;
      end else begin
        if (!DCache_ready) obs_low++;
        if (mem_req) begin
          if (!obs_req_seen) begin
            obs_req_seen = 1'b1; since_req = 0;
            obs_wr = mem_wr; obs_addr = mem_addr; obs_wdata = mem_wdata; obs_wstrb = mem_wstrb;
          end else begin
            since_req++;
            if (mem_wr !== obs_wr || mem_addr !== obs_addr || mem_wdata !== obs_wdata || mem_wstrb !== obs_wstrb)
              obs_unstable = 1'b1;
          end
          if (!acked && since_req == ack_dly) begin mem_addr_ok = 1'b1; acked = 1; since_ack = 0; end
        end else if (acked) since_ack++;
        if (acked && !data_sent && since_ack == data_dly) begin mem_data_ok = 1'b1; data_sent = 1; end
      end
    end
    flush = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (DCache_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", DCache_ready); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", mem_req); end
    n_vec++; if ({mem_wr, mem_wstrb} !== 5'h0) begin n_err++; $display("FAIL reset_wr_wstrb: got %b want 0", {mem_wr, mem_wstrb}); end
    n_vec++; if ({mem_addr, mem_wdata, load_data} !== 96'h0) begin n_err++; $display("FAIL reset_addr_wdata_ld: got %h want 0", {mem_addr, mem_wdata, load_data}); end
    n_vec++; if (ale !== 1'b0) begin n_err++; $display("FAIL reset_ale: got %b want 0", ale); end
`ifdef LSU_PERF_CNT_EN
    n_vec++; if ({load_cnt, store_cnt, stall_cnt} !== 96'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", {load_cnt, store_cnt, stall_cnt}); end
`endif
  endtask

  task automatic test_load_word();
    run_access(OP_LDW, 32'h1000, 32'h0, 32'hDEADBEEF, 2, 3, 0);
    n_vec++; if (obs_timeout !== 1'b0) begin n_err++; $display("FAIL ldw_timeout: got %b want 0", obs_timeout); end
    n_vec++; if (obs_ready0 !== 1'b0) begin n_err++; $display("FAIL ldw_ready_first: got %b want 0", obs_ready0); end
    n_vec++; if (obs_low !== 6) begin n_err++; $display("FAIL ldw_low_cycles: got %0d want 6", obs_low); end
    n_vec++; if (obs_ld !== 32'hDEADBEEF) begin n_err++; $display("FAIL ldw_data: got %h want deadbeef", obs_ld); end
    n_vec++; if ({obs_wr, obs_wstrb} !== 5'h0) begin n_err++; $display("FAIL ldw_wr_wstrb: got %b want 0", {obs_wr, obs_wstrb}); end
    n_vec++; if (obs_addr !== 32'h1000) begin n_err++; $display("FAIL ldw_addr: got %h want 00001000", obs_addr); end
    n_vec++; if (obs_unstable !== 1'b0) begin n_err++; $display("FAIL ldw_req_stable: got %b want 0", obs_unstable); end
    retire();
  endtask

  task automatic test_load_ext();
    logic [9:0]  ops [3];
    logic [31:0] adrs [3];
    logic [31:0] want [3];
    ops = '{OP_LDB, OP_LDBU, OP_LDHU};
    adrs = '{32'h1003, 32'h1003, 32'h1002};
    want = '{32'hFFFFFF80, 32'h00000080, 32'h00008011};
    for (int k = 0; k < 3; k++) begin
      run_access(ops[k], adrs[k], 32'h0, 32'h80112233, 1, 1, 0);
      n_vec++; if (obs_ld !== want[k]) begin n_err++; $display("FAIL ld_ext_%0d: got %h want %h", k, obs_ld, want[k]); end
      retire();
    end
  endtask

  task automatic test_store_half();
    run_access(OP_STH, 32'h2002, 32'h1234ABCD, 32'hFFFFFFFF, 0, 2, 0);
    n_vec++; if (obs_wr !== 1'b1) begin n_err++; $display("FAIL sth_wr: got %b want 1", obs_wr); end
    n_vec++; if (obs_addr !== 32'h2000) begin n_err++; $display("FAIL sth_addr: got %h want 00002000", obs_addr); end
    n_vec++; if (obs_wstrb !== 4'b1100) begin n_err++; $display("FAIL sth_wstrb: got %b want 1100", obs_wstrb); end
    n_vec++; if (obs_wdata !== 32'hABCDABCD) begin n_err++; $display("FAIL sth_wdata: got %h want abcdabcd", obs_wdata); end
    n_vec++; if (obs_ld !== 32'h0) begin n_err++; $display("FAIL sth_load_data: got %h want 0", obs_ld); end
    retire();
  endtask

  task automatic test_misaligned();
    logic [9:0]  ops [6];
    logic [31:0] adrs [6];
    logic        want_ale [6];
    bit          saw_req;
    ops = '{OP_LDW, OP_LDH, OP_STW, OP_STH, OP_LDHU, 10'h0A3};
    adrs = '{32'h1002, 32'h1001, 32'h2003, 32'h3001, 32'h0005, 32'h1001};
    want_ale = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      inst = {ops[k], 22'($urandom)}; inst_valid = 1'b1; addr = adrs[k]; st_data = $urandom;
      #1;
      n_vec++; if (ale !== want_ale[k]) begin n_err++; $display("FAIL mis_ale_%0d: got %b want %b", k, ale, want_ale[k]); end
      n_vec++; if (DCache_ready !== 1'b1) begin n_err++; $display("FAIL mis_ready_%0d: got %b want 1", k, DCache_ready); end
      saw_req = 0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #2;
        if (mem_req !== 1'b0 || DCache_ready !== 1'b1) saw_req = 1;
      end
      n_vec++; if (saw_req !== 1'b0) begin n_err++; $display("FAIL mis_no_req_%0d: got %b want 0", k, saw_req); end
      inst_valid = 1'b0;
    end
  endtask

  task automatic test_flush_wait();
    do_reset();
    run_access(OP_LDW, 32'h1000, 32'h0, 32'h55AA55AA, 0, 3, 2);
    n_vec++; if (obs_timeout !== 1'b0) begin n_err++; $display("FAIL flush_timeout: got %b want 0", obs_timeout); end
    n_vec++; if (obs_low !== 4) begin n_err++; $display("FAIL flush_low_cycles: got %0d want 4", obs_low); end
`ifdef LSU_PERF_CNT_EN
    n_vec++; if (load_cnt !== 32'd0) begin n_err++; $display("FAIL flush_load_cnt: got %0d want 0", load_cnt); end
    n_vec++; if (stall_cnt !== 32'd5) begin n_err++; $display("FAIL flush_stall_cnt: got %0d want 5", stall_cnt); end
`endif
    inst = {OP_LDW, 22'h0}; inst_valid = 1'b1; addr = 32'h1004;
    #1;
    n_vec++; if (DCache_ready !== 1'b0) begin n_err++; $display("FAIL flush_back_to_idle: got %b want 0", DCache_ready); end
    run_access(OP_LDW, 32'h1004, 32'h0, 32'h01020304, 1, 0, 0);
    n_vec++; if (obs_ld !== 32'h01020304) begin n_err++; $display("FAIL flush_next_load: got %h want 01020304", obs_ld); end
    retire();
  endtask

  task automatic test_reset_mid();
    inst = {OP_LDW, 22'h0}; inst_valid = 1'b1; addr = 32'h1000; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rstmid_req_before: got %b want 1", mem_req); end
    rst = 1'b1; inst_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rstmid_req: got %b want 0", mem_req); end
    n_vec++; if (DCache_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", DCache_ready); end
    n_vec++; if ({mem_addr, mem_wstrb, load_data} !== 68'h0) begin n_err++; $display("FAIL rstmid_fields: got %h want 0", {mem_addr, mem_wstrb, load_data}); end
`ifdef LSU_PERF_CNT_EN
    n_vec++; if ({load_cnt, store_cnt, stall_cnt} !== 96'h0) begin n_err++; $display("FAIL rstmid_cnt: got %h want 0", {load_cnt, store_cnt, stall_cnt}); end
`endif
    run_access(OP_STW, 32'h4008, 32'hCAFEF00D, 32'h0, 0, 1, 0);
    n_vec++; if (obs_timeout !== 1'b0) begin n_err++; $display("FAIL rstmid_stw_timeout: got %b want 0", obs_timeout); end
    n_vec++; if ({obs_wr, obs_wstrb} !== 5'b11111) begin n_err++; $display("FAIL rstmid_stw_wr_wstrb: got %b want 11111", {obs_wr, obs_wstrb}); end
    n_vec++; if ({obs_addr, obs_wdata} !== {32'h4008, 32'hCAFEF00D}) begin n_err++; $display("FAIL rstmid_stw_addr_data: got %h want 00004008cafef00d", {obs_addr, obs_wdata}); end
    retire();
  endtask

  task automatic test_random();
    logic [9:0]  ops [8];
    logic [9:0]  opc;
    logic [1:0]  off;
    logic [31:0] a, sd, rd;
    int ack_dly, data_dly, exp_loads, exp_stores, exp_stall;
    ops = '{OP_LDB, OP_LDH, OP_LDW, OP_STB, OP_STH, OP_STW, OP_LDBU, OP_LDHU};
    do_reset();
    exp_loads = 0; exp_stores = 0; exp_stall = 0;
    for (int it = 0; it < 40; it++) begin
      opc = ops[$urandom_range(7, 0)];
      off = 2'($urandom);
      if (opc == OP_LDH || opc == OP_LDHU || opc == OP_STH) off[0] = 1'b0;
      if (opc == OP_LDW || opc == OP_STW) off = 2'b00;
      a = {30'($urandom), off};
      sd = $urandom; rd = $urandom;
      ack_dly = $urandom_range(3, 0); data_dly = $urandom_range(3, 0);
      run_access(opc, a, sd, rd, ack_dly, data_dly, 0);
      if (is_store_op(opc)) exp_stores++; else exp_loads++;
      exp_stall += 2 + ack_dly + data_dly;
      n_vec++;
      if (obs_timeout !== 1'b0 || obs_ale !== 1'b0 || obs_ready0 !== 1'b0 || obs_unstable !== 1'b0 ||
          obs_low !== ack_dly + data_dly + 1) begin
        n_err++;
        $display("FAIL rnd_handshake_%0d: got to=%b ale=%b rdy0=%b unst=%b low=%0d want 0 0 0 0 %0d",
                 it, obs_timeout, obs_ale, obs_ready0, obs_unstable, obs_low, ack_dly + data_dly + 1);
      end
      n_vec++;
      if (obs_wr !== is_store_op(opc) || obs_addr !== {a[31:2], 2'b00} ||
          obs_wstrb !== ref_wstrb(opc, off) || obs_wdata !== ref_wdata(opc, sd)) begin
        n_err++;
        $display("FAIL rnd_request_%0d: got wr=%b addr=%h strb=%b wdata=%h want %b %h %b %h", it, obs_wr, obs_addr,
                 obs_wstrb, obs_wdata, is_store_op(opc), {a[31:2], 2'b00}, ref_wstrb(opc, off), ref_wdata(opc, sd));
      end
      n_vec++;
      if (obs_ld !== ref_load(opc, off, rd)) begin
        n_err++; $display("FAIL rnd_load_data_%0d: got %h want %h", it, obs_ld, ref_load(opc, off, rd));
      end
      retire();
    end
`ifdef LSU_PERF_CNT_EN
    n_vec++; if (load_cnt !== 32'(exp_loads)) begin n_err++; $display("FAIL rnd_load_cnt: got %0d want %0d", load_cnt, exp_loads); end
    n_vec++; if (store_cnt !== 32'(exp_stores)) begin n_err++; $display("FAIL rnd_store_cnt: got %0d want %0d", store_cnt, exp_stores); end
    n_vec++; if (stall_cnt !== 32'(exp_stall)) begin n_err++; $display("FAIL rnd_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
`endif
  endtask

  initial begin
    inst = 32'h0; addr = 32'h0; st_data = 32'h0; mem_rdata = 32'h0;
    do_reset();
    test_reset();
    test_load_word();
    test_load_ext();
    test_store_half();
    test_misaligned();
    test_flush_wait();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
